// File: rtl/ycbcr_block_to_rgb_pkg.sv
// Shared constants and types for the YCbCr -> RGB block converter.
// Coefficients are JFIF BT.601 full-range, scaled by 2^FRAC.
package jpeg_color_pkg;

    localparam int FRAC = 8;
    localparam logic signed [18:0] C_RCR = 19'sd359;
    localparam logic signed [18:0] C_GCB = 19'sd88;
    localparam logic signed [18:0] C_GCR = 19'sd183;
    localparam logic signed [18:0] C_BCB = 19'sd454;
    localparam logic signed [18:0] ROUND = 19'sd1 <<< (FRAC - 1);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} cc_state_t;

    function automatic logic [7:0] clamp8(input logic signed [10:0] v);
        if (v < 0)
            return 8'h00;
        if (v > 11'sd255)
            return 8'hFF;
        return v[7:0];
    endfunction

endpackage

// File: rtl/ycbcr_block_to_rgb_if.sv
// Block-in and row-out handshake bundles for the colour converter.
interface ycc_blk_if #(parameter int Q = 8);
    logic                     valid_in;
    logic                     ready_out;
    logic [7:0][7:0][Q-1:0]   y_in;
    logic [7:0][7:0][Q-1:0]   cb_in;
    logic [7:0][7:0][Q-1:0]   cr_in;

    modport master (output valid_in, y_in, cb_in, cr_in, input ready_out);
    modport slave  (input valid_in, y_in, cb_in, cr_in, output ready_out);
endinterface

interface rgb_row_if;
    logic [7:0][7:0] r_row;
    logic [7:0][7:0] g_row;
    logic [7:0][7:0] b_row;
    logic [2:0]      row_idx;
    logic            last_row;
    logic            valid_out;
    logic            ready_in;

    modport master (output r_row, g_row, b_row, row_idx, last_row, valid_out, input ready_in);
    modport slave  (input r_row, g_row, b_row, row_idx, last_row, valid_out, output ready_in);
endinterface

// File: rtl/ycbcr_block_to_rgb_pixel.sv
// One-pixel YCbCr -> RGB converter: stage 1 registers products, stage 2
// registers the rounded, clamped result. Both stages advance on en.
module ycc_pixel_to_rgb
    import jpeg_color_pkg::*;
#(
    parameter int Q = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [Q-1:0] y,
    input  logic [Q-1:0] cb,
    input  logic [Q-1:0] cr,
    output rgb8_t        rgb
);

    logic [7:0]         y8, cb8, cr8, y_q;
    logic signed [8:0]  dcb, dcr;
    logic signed [18:0] pr_d, pg_d, pb_d, pr_q, pg_q, pb_q;
    logic signed [18:0] rs, gs, bs;
    logic signed [10:0] yw;
    rgb8_t              rgb_d;

    always_comb begin
        y8   = (y  > Q'(255)) ? 8'hFF : y[7:0];
        cb8  = (cb > Q'(255)) ? 8'hFF : cb[7:0];
        cr8  = (cr > Q'(255)) ? 8'hFF : cr[7:0];
        dcb  = $signed({1'b0, cb8}) - 9'sd128;
        dcr  = $signed({1'b0, cr8}) - 9'sd128;
        pr_d = C_RCR * 19'(dcr);
        pg_d = C_GCB * 19'(dcb) + C_GCR * 19'(dcr);
        pb_d = C_BCB * 19'(dcb);
    end

    // Arithmetic shift floors negative chroma terms.
    always_comb begin
        rs      = (pr_q + ROUND) >>> FRAC;
        gs      = (pg_q + ROUND) >>> FRAC;
        bs      = (pb_q + ROUND) >>> FRAC;
        yw      = $signed({3'b000, y_q});
        rgb_d.r = clamp8(yw + 11'(rs));
        rgb_d.g = clamp8(yw - 11'(gs));
        rgb_d.b = clamp8(yw + 11'(bs));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q  <= '0;
            pr_q <= '0;
            pg_q <= '0;
            pb_q <= '0;
            rgb  <= '0;
        end else if (en) begin
            y_q  <= y8;
            pr_q <= pr_d;
            pg_q <= pg_d;
            pb_q <= pb_d;
            rgb  <= rgb_d;
        end
    end

endmodule

// File: rtl/ycbcr_block_to_rgb.sv
// Captures an 8x8 Y/Cb/Cr block triple and streams it out as RGB rows,
// one row per cycle, through a 2-stage stallable pipeline.
module ycbcr_block_to_rgb
    import jpeg_color_pkg::*;
#(
    parameter int Q = 8
) (
    input  logic      clk,
    input  logic      rst,
    ycc_blk_if.slave  blk,
    rgb_row_if.master row
);

    localparam int STAGES = 2;

    cc_state_t              state, state_nxt;
    logic [2:0]             cnt, idx_s1;
    logic [STAGES:1]        vld_pipe;
    logic                   en, issue, accept, last_hs;
    logic [7:0][7:0][Q-1:0] cap_y, cap_cb, cap_cr;
    rgb8_t [7:0]            px;

    assign en      = !vld_pipe[STAGES] || row.ready_in;
    assign accept  = blk.valid_in && (state == IDLE);
    assign last_hs = vld_pipe[STAGES] && row.last_row && row.ready_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (blk.valid_in)       state_nxt = ISSUE;
            ISSUE:   if (en && cnt == 3'd7)  state_nxt = DRAIN;
            DRAIN:   if (last_hs)            state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        blk.ready_out = (state == IDLE);
        issue         = (state == ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            cap_y  <= '0;
            cap_cb <= '0;
            cap_cr <= '0;
        end else if (accept) begin
            cnt    <= '0;
            cap_y  <= blk.y_in;
            cap_cb <= blk.cb_in;
            cap_cr <= blk.cr_in;
        end else if (issue && en) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Row index and valid travel alongside the pixel data, frozen together on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe     <= '0;
            idx_s1       <= '0;
            row.row_idx  <= '0;
            row.last_row <= 1'b0;
        end else if (en) begin
            vld_pipe     <= {vld_pipe[STAGES-1:1], issue};
            idx_s1       <= cnt;
            row.row_idx  <= idx_s1;
            row.last_row <= vld_pipe[1] && (idx_s1 == 3'd7);
        end
    end

    assign row.valid_out = vld_pipe[STAGES];

    for (genvar c = 0; c < 8; c++) begin : g_col
        ycc_pixel_to_rgb #(.Q(Q)) u_px (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .y   (cap_y[cnt][c]),
            .cb  (cap_cb[cnt][c]),
            .cr  (cap_cr[cnt][c]),
            .rgb (px[c])
        );
    end

    always_comb begin
        row.r_row = '0;
        row.g_row = '0;
        row.b_row = '0;
        for (int c = 0; c < 8; c++) begin
            row.r_row[c] = px[c].r;
            row.g_row[c] = px[c].g;
            row.b_row[c] = px[c].b;
        end
    end

endmodule

// File: tb/tb_ycbcr_block_to_rgb.sv
// Directed bench for ycbcr_block_to_rgb: table of uniform-block colour vectors
// plus stall, back-to-back, reset-mid-block and saturation sequences.
module tb_ycbcr_block_to_rgb;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ycc_blk_if #(.Q(Q)) blk ();
    rgb_row_if          row ();

    ycbcr_block_to_rgb #(.Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .blk (blk),
        .row (row)
    );

    typedef struct {
        int         y, cb, cr;
        logic [7:0] r, g, b;
    } vec_t;

    vec_t vecs[8];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_uniform(input int y, input int cb, input int cr);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                blk.y_in[r][c]  = Q'(y);
                blk.cb_in[r][c] = Q'(cb);
                blk.cr_in[r][c] = Q'(cr);
            end
    endtask

    task automatic set_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                blk.y_in[r][c]  = Q'(8 * r + c);
                blk.cb_in[r][c] = Q'(128);
                blk.cr_in[r][c] = Q'(128);
            end
    endtask

    // Raise valid_in and return #1 after the accepting edge.
    task automatic send_block(input bit hold);
        int w = 0;
        @(negedge clk);
        blk.valid_in = 1'b1;
        while (!blk.ready_out && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!blk.ready_out) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: ready_out never rose");
        end
        @(posedge clk);
        #1;
        if (!hold) blk.valid_in = 1'b0;
    endtask

    // Drain 8 rows, checking data, order, last_row, latency and stall hold.
    task automatic collect(input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                           input bit ramp, input int stall_row, input int stall_len);
        int k = 0;
        int stalls = 0;
        int first = -1;
        int ro_bad = 0;
        logic [199:0] snap, cur;
        logic [7:0][7:0] xr, xg, xb;
        snap = '0;
        for (int n = 0; n < 60 && k < 8; n++) begin
            @(negedge clk);
            if (blk.ready_out) ro_bad++;
            if (row.valid_out && first < 0) first = n;
            cur = {row.row_idx, row.last_row, row.r_row, row.g_row, row.b_row};
            if (row.valid_out && stalls < stall_len && int'(row.row_idx) == stall_row) begin
                row.ready_in = 1'b0;
                if (stalls == 0) snap = cur;
                else chk("stall_hold", cur, snap);
                stalls++;
            end else begin
                row.ready_in = 1'b1;
                if (row.valid_out) begin
                    for (int c = 0; c < 8; c++) begin
                        xr[c] = ramp ? 8'(8 * k + c) : er;
                        xg[c] = ramp ? 8'(8 * k + c) : eg;
                        xb[c] = ramp ? 8'(8 * k + c) : eb;
                    end
                    chk("row_rgb", {row.r_row, row.g_row, row.b_row}, {xr, xg, xb});
                    chk("row_idx", 200'(row.row_idx), 200'(k));
                    chk("last_row", 200'(row.last_row), 200'(k == 7));
                    if (k == 7) chk("last_row_cycle", 200'(n), 200'(9 + stall_len));
                    k++;
                end
            end
        end
        if (k < 8) begin
            n_chk++;
            n_fail++;
            $display("FAIL row_timeout: got %0d rows expected 8", k);
        end
        chk("first_valid_latency", 200'(first), 200'(2));
        chk("ready_out_low_in_block", 200'(ro_bad), 200'(0));
    endtask

    initial begin
        vecs[0] = '{128, 128, 128, 8'd128, 8'd128, 8'd128};
        vecs[1] = '{255, 128, 255, 8'd255, 8'd164, 8'd255};
        vecs[2] = '{0,   255, 128, 8'd0,   8'd0,   8'd225};
        vecs[3] = '{0,   0,   0,   8'd0,   8'd135, 8'd0};
        vecs[4] = '{50,  200, 60,  8'd0,   8'd74,  8'd178};
        vecs[5] = '{300, 128, 128, 8'd255, 8'd255, 8'd255};
        vecs[6] = '{300, 1023, 128, 8'd255, 8'd211, 8'd255};
        vecs[7] = '{100, 128, 300, 8'd255, 8'd9,   8'd100};

        blk.valid_in = 1'b0;
        row.ready_in = 1'b1;
        set_uniform(0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready_out", 200'(blk.ready_out), 200'(1));
        chk("rst_valid_out", 200'(row.valid_out), 200'(0));
        chk("rst_last_row", 200'(row.last_row), 200'(0));
        chk("rst_row_idx", 200'(row.row_idx), 200'(0));
        chk("rst_rgb", {row.r_row, row.g_row, row.b_row}, 200'(0));
        rst = 1'b1;

        // Uniform-colour table, including saturated inputs
        for (int i = 0; i < 8; i++) begin
            set_uniform(vecs[i].y, vecs[i].cb, vecs[i].cr);
            send_block(1'b0);
            collect(vecs[i].r, vecs[i].g, vecs[i].b, 1'b0, 0, 0);
        end

        // Ramp block with a 3-cycle stall on row 2
        set_ramp();
        send_block(1'b0);
        collect(8'd0, 8'd0, 8'd0, 1'b1, 2, 3);

        // Back-to-back blocks with valid_in held high
        set_uniform(255, 128, 255);
        send_block(1'b1);
        set_uniform(0, 255, 128);
        collect(8'd255, 8'd164, 8'd255, 1'b0, 0, 0);
        @(negedge clk);
        chk("ready_out_rise", 200'(blk.ready_out), 200'(1));
        @(posedge clk);
        #1;
        blk.valid_in = 1'b0;
        collect(8'd0, 8'd0, 8'd225, 1'b0, 0, 0);

        // Async reset in the middle of a block
        set_ramp();
        send_block(1'b0);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 30 && !seen; n++) begin
                @(negedge clk);
                row.ready_in = 1'b1;
                if (row.valid_out && row.row_idx == 3'd4) seen = 1'b1;
            end
            chk("reached_row4", 200'(seen), 200'(1));
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_valid_out", 200'(row.valid_out), 200'(0));
        chk("arst_row_idx", 200'(row.row_idx), 200'(0));
        chk("arst_last_row", 200'(row.last_row), 200'(0));
        chk("arst_rgb", {row.r_row, row.g_row, row.b_row}, 200'(0));
        chk("arst_ready_out", 200'(blk.ready_out), 200'(1));
        @(negedge clk);
        rst = 1'b1;
        set_uniform(0, 0, 0);
        send_block(1'b0);
        collect(8'd0, 8'd135, 8'd0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
